dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing array (power of two, >=16).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dmem_req  input  1  request valid from the pipeline.
REQ-006 SHALL have port dmem_addr  input  32  byte address; word index = dmem_addr[log2(DEPTH_WORDS)+1:2].
REQ-007 SHALL have port dmem_rmask  input  4  byte-lane read mask.
REQ-008 SHALL have port dmem_wmask  input  4  byte-lane write mask.
REQ-009 SHALL have port dmem_wdata  input  32  store data, lane i = bits 8i+7:8i.
REQ-010 SHALL have port dmem_ready  output  1  request accepted this cycle when high with dmem_req.
REQ-011 SHALL have port dmem_resp  output  1  one-cycle response pulse.
REQ-012 SHALL have port dmem_rdata  output  32  full word read, valid only while dmem_resp=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 SHALL assert dmem_ready in IDLE and RESP; SHALL deassert it in WAIT.
REQ-015 SHALL accept a request when dmem_req && dmem_ready, capturing addr, rmask, wmask, wdata at that edge.
REQ-016 SHALL assert dmem_resp exactly LATENCY cycles after the accept cycle, for one cycle, with no further pulse until the next acceptance.
REQ-017 SHALL transition on accept to RESP if LATENCY=1, else to WAIT, loading a down-counter with LATENCY-1; WAIT->RESP when counter reaches 0.
REQ-018 SHALL transition RESP->IDLE when no request is accepted; RESP->WAIT/RESP on back-to-back accept (zero bubble).
REQ-019 SHALL return the word's pre-write contents on dmem_rdata, so rmask and wmask both nonzero is read-before-write.
REQ-020 SHALL commit the write in the RESP cycle, updating only lanes with wmask bit set.
REQ-021 SHALL drive dmem_rdata = 0 when dmem_resp = 0.
REQ-022 SHALL ignore dmem_addr[1:0]; misaligned requests act on the containing word.
REQ-023 SHALL, for a request with rmask=wmask=0, respond with the normal latency and leave the array unchanged.
REQ-024 SHALL ignore input changes in WAIT; captured values govern the transaction.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force state IDLE, counter 0, dmem_resp 0, dmem_rdata 0, dmem_ready 0 while rst_n is low, then 1 in IDLE.
REQ-026 SHALL drop any in-flight transaction on reset (no response, no write); array contents are not reset.

Configuration
REQ-027 SHALL, with DMEM_BOUNDS_CHECK_EN defined, treat a request with dmem_addr >= 4*DEPTH_WORDS as out-of-range: response still issued at normal latency, dmem_rdata = 32'hDEADBEEF, write suppressed, extra output dmem_err pulses with dmem_resp.
REQ-028 SHALL, without DMEM_BOUNDS_CHECK_EN, omit dmem_err and wrap addresses modulo 4*DEPTH_WORDS.

Structure
REQ-029 SHALL place dmem_state_t (IDLE/WAIT/RESP enum) and constant DMEM_OOR_RDATA in package rv32i_types.
REQ-030 SHALL isolate the byte-masked word array in sub-module dmem_sram_array (one read, one masked-write port, synchronous).

Verification
REQ-031 SHALL cover: LATENCY=2, write addr 0x10 wmask 4'hF wdata 0xA5A5_1234, then read 0x10 rmask 4'hF -> each resp 2 cycles after accept, read rdata 0xA5A5_1234.
REQ-032 SHALL cover: word 0x20 = 0x11223344, write wmask 4'b0100 wdata 0x00AA0000, read -> 0x11AA3344.
REQ-033 SHALL cover: dmem_req held high for 3 reads at 0x0,0x4,0x8, LATENCY=1 -> resp on 3 consecutive cycles, no bubble.
REQ-034 SHALL cover: rmask=wmask=4'hF at 0x30 (old 0x0), wdata 0xFFFF0000 -> rdata 0x0; following read -> 0xFFFF0000.
REQ-035 SHALL cover: rst_n pulsed low in WAIT after write to 0x40 -> no dmem_resp, word 0x40 unchanged, dmem_ready=1 after release.
REQ-036 SHALL cover (DMEM_BOUNDS_CHECK_EN, DEPTH_WORDS=1024): read 0x1000 -> dmem_resp with dmem_err=1, rdata 0xDEADBEEF; write 0x1000 -> array unchanged.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types : shared types and constants for the data-memory responder.
//   dmem_state_t   : responder FSM encoding (IDLE / WAIT / RESP)
//   DMEM_OOR_RDATA : read data returned for out-of-range requests
//                    (used only when DMEM_BOUNDS_CHECK_EN is defined)
// -----------------------------------------------------------------------------
package rv32i_types;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam logic [31:0] DMEM_OOR_RDATA = 32'hDEAD_BEEF;

   // Down-counter preload for a given response latency.
   function automatic logic [3:0] dmem_cnt_load(input int unsigned lat);
      return 4'(lat - 1);
   endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// -----------------------------------------------------------------------------
// dmem_sram_array : byte-masked 32-bit word array, one synchronous read port
// and one synchronous masked-write port.
//   clk        in   clock
//   i_rd_en    in   capture a read this edge
//   i_rd_addr  in   read word index
//   o_rd_data  out  registered read data
//   i_wr_en    in   commit a write this edge
//   i_wr_addr  in   write word index
//   i_wr_mask  in   byte-lane write enables
//   i_wr_data  in   write data, lane i = bits 8i+7:8i
// A read and a write to the same word on the same edge return the written
// lanes, so a back-to-back transaction observes the preceding store.
// -----------------------------------------------------------------------------
module dmem_sram_array #(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           i_rd_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_rd_addr,
   output logic [31:0]                    o_rd_data,
   input  logic                           i_wr_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_wr_addr,
   input  logic [3:0]                     i_wr_mask,
   input  logic [31:0]                    i_wr_data
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rd_data;
   logic        w_same;

   assign w_same = i_wr_en && (i_wr_addr == i_rd_addr);

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 4; i++) begin
         if (i_wr_en && i_wr_mask[i])
            r_mem[i_wr_addr][8*i +: 8] <= i_wr_data[8*i +: 8];
         if (i_rd_en) begin
            if (w_same && i_wr_mask[i])
               r_rd_data[8*i +: 8] <= i_wr_data[8*i +: 8];
            else
               r_rd_data[8*i +: 8] <= r_mem[i_rd_addr][8*i +: 8];
         end
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder : fixed-latency data-memory responder for a pipelined core.
// Parameters: DEPTH_WORDS (power of two, >=16), LATENCY (1..15).
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   dmem_req    in   request valid
//   dmem_addr   in   byte address (bits [1:0] ignored)
//   dmem_rmask  in   byte-lane read mask
//   dmem_wmask  in   byte-lane write mask
//   dmem_wdata  in   store data
//   dmem_ready  out  request accepted when high together with dmem_req
//   dmem_resp   out  one-cycle response pulse, LATENCY cycles after accept
//   dmem_err    out  out-of-range flag, pulses with dmem_resp
//                    (present only with DMEM_BOUNDS_CHECK_EN defined)
//   dmem_rdata  out  pre-write word contents, zero when dmem_resp is low
// Build option: DMEM_BOUNDS_CHECK_EN -- addresses >= 4*DEPTH_WORDS return
// DMEM_OOR_RDATA with dmem_err and do not write; otherwise addresses wrap.
// -----------------------------------------------------------------------------
module dmem_responder
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dmem_req,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic        dmem_ready,
   output logic        dmem_resp,
`ifdef DMEM_BOUNDS_CHECK_EN
   output logic        dmem_err,
`endif
   output logic [31:0] dmem_rdata
);

   localparam int unsigned AW          = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  LP_CNT_LOAD = dmem_cnt_load(LATENCY);

   dmem_state_t   r_state, w_next;
   logic [3:0]    r_cnt;
   logic [AW-1:0] r_word;
   logic [3:0]    r_rmask, r_wmask;
   logic [31:0]   r_wdata;
   logic          r_oor;
   logic          w_oor_in;
   logic          w_accept;
   logic          w_rd_en, w_wr_en;
   logic [AW-1:0] w_rd_addr;
   logic [31:0]   w_rd_data;
   logic          w_unused;

   assign w_accept = dmem_req && dmem_ready;

`ifdef DMEM_BOUNDS_CHECK_EN
   assign w_oor_in = ({1'b0, dmem_addr} >= (33'(DEPTH_WORDS) << 2));
`else
   assign w_oor_in = 1'b0;
`endif

   // rmask does not change the returned word; upper address bits only
   // matter for the bounds check.
   assign w_unused = ^{dmem_addr[1:0], dmem_addr[31:AW+2], r_rmask};

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // ---------------- capture + latency counter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_word  <= '0;
         r_rmask <= '0;
         r_wmask <= '0;
         r_wdata <= '0;
         r_oor   <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= LP_CNT_LOAD;
         r_word  <= dmem_addr[AW+1:2];
         r_rmask <= dmem_rmask;
         r_wmask <= dmem_wmask;
         r_wdata <= dmem_wdata;
         r_oor   <= w_oor_in;
      end else if (r_state == WAIT && r_cnt != '0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // ---------------- next-state ----------------
   // WAIT holds for LATENCY-1 cycles: leave when the counter is about to hit 0.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, RESP: begin
            if (w_accept) w_next = (LATENCY == 1) ? RESP : WAIT;
            else          w_next = IDLE;
         end
         WAIT:    if (r_cnt <= 4'd1) w_next = RESP;
         default: w_next = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      dmem_ready = 1'b0;
      dmem_resp  = 1'b0;
      dmem_rdata = '0;
`ifdef DMEM_BOUNDS_CHECK_EN
      dmem_err   = 1'b0;
`endif
      case (r_state)
         IDLE: dmem_ready = rst_n;
         RESP: begin
            dmem_ready = rst_n;
            dmem_resp  = 1'b1;
            dmem_rdata = r_oor ? DMEM_OOR_RDATA : w_rd_data;
`ifdef DMEM_BOUNDS_CHECK_EN
            dmem_err   = r_oor;
`endif
         end
         default: ;
      endcase
   end

   // The word is read on the edge entering RESP and written on the edge
   // leaving it, giving read-before-write within one transaction. With
   // LATENCY=1 a new accept uses the live address, not the captured one.
   assign w_rd_en   = (w_next == RESP);
   assign w_rd_addr = w_accept ? dmem_addr[AW+1:2] : r_word;
   assign w_wr_en   = (r_state == RESP) && (|r_wmask) && !r_oor;

   dmem_sram_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk       (clk),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_word),
      .i_wr_mask (r_wmask),
      .i_wr_data (r_wdata)
   );

endmodule
